// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, load/store opcodes and alignment helper for the MEM-stage
// memory access controller.
package mem_access_ctrl_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [3:0]  mem_sel_t;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  // Unaligned-by-design ops (LWL/LWR/SWL/SWR) and byte ops never trap.
  function automatic logic isMisaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return (a != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Combinational lane extraction, extension and LWL/LWR merge of a returned
// data word, relative to byte offset a.
module load_formatter
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  mem_op,
  input  logic        sign_ext,
  input  logic [1:0]  a,
  input  logic [31:0] mem_data,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (a)
      2'd0: w_byte = mem_data[7:0];
      2'd1: w_byte = mem_data[15:8];
      2'd2: w_byte = mem_data[23:16];
      2'd3: w_byte = mem_data[31:24];
    endcase
  end

  assign w_half = a[1] ? mem_data[31:16] : mem_data[15:0];

  // LWL fills from the most significant end, LWR from the least significant end.
  always_comb begin
    result = mem_data;
    case (mem_op)
      OP_LB, OP_LBU: result = {{24{sign_ext & w_byte[7]}}, w_byte};
      OP_LH, OP_LHU: result = {{16{sign_ext & w_half[15]}}, w_half};
      OP_LWL: begin
        case (a)
          2'd0: result = {mem_data[7:0],  rt[23:0]};
          2'd1: result = {mem_data[15:0], rt[15:0]};
          2'd2: result = {mem_data[23:0], rt[7:0]};
          2'd3: result = mem_data;
        endcase
      end
      OP_LWR: begin
        case (a)
          2'd0: result = mem_data;
          2'd1: result = {rt[31:24], mem_data[31:8]};
          2'd2: result = {rt[31:16], mem_data[31:16]};
          2'd3: result = {rt[31:8],  mem_data[31:24]};
        endcase
      end
      default: result = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns each load/store into one valid/ready data-RAM
// transaction, stalls the pipeline until it completes and formats the result.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [5:0]  mem_op,
  input  logic [31:0] address,
  input  logic [31:0] result_in,
  input  logic        flush,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic [31:0] result,
  output logic        stall_request,
  output logic        addr_error_load,
  output logic        addr_error_store
);

  mem_state_e  r_state;
  logic [31:0] r_readData;
  logic [31:0] r_reqAddr;
  logic [31:0] r_reqData;
  logic [3:0]  r_reqStrobe;
  logic        r_flushSeen;

  logic [1:0]  w_a;
  logic        w_memInst;
  logic        w_misaligned;
  logic        w_access;
  logic [31:0] w_wordAddr;
  logic [3:0]  w_storeStrobe;
  logic [31:0] w_storeData;
  logic [31:0] w_loadResult;

  assign w_a          = address[1:0];
  assign w_memInst    = mem_read_flag | mem_write_flag;
  assign w_misaligned = ALIGN_CHECK && isMisaligned(mem_op, w_a);
  assign w_access     = w_memInst & ~flush & ~w_misaligned;
  assign w_wordAddr   = {address[31:2], 2'b00};

  // Store lane steering; reads leave strobe and data at zero.
  always_comb begin
    w_storeStrobe = 4'b0000;
    w_storeData   = 32'h0;
    if (mem_write_flag) begin
      case (mem_op)
        OP_SWL: begin
          case (w_a)
            2'd0: begin w_storeStrobe = 4'b0001; w_storeData = {24'h0, mem_write_data[31:24]}; end
            2'd1: begin w_storeStrobe = 4'b0011; w_storeData = {16'h0, mem_write_data[31:16]}; end
            2'd2: begin w_storeStrobe = 4'b0111; w_storeData = {8'h0,  mem_write_data[31:8]};  end
            2'd3: begin w_storeStrobe = 4'b1111; w_storeData = mem_write_data;                 end
          endcase
        end
        OP_SWR: begin
          case (w_a)
            2'd0: begin w_storeStrobe = 4'b1111; w_storeData = mem_write_data;                 end
            2'd1: begin w_storeStrobe = 4'b1110; w_storeData = {mem_write_data[23:0], 8'h0};  end
            2'd2: begin w_storeStrobe = 4'b1100; w_storeData = {mem_write_data[15:0], 16'h0}; end
            2'd3: begin w_storeStrobe = 4'b1000; w_storeData = {mem_write_data[7:0],  24'h0}; end
          endcase
        end
        OP_SB: begin
          w_storeStrobe = mem_sel << w_a;
          w_storeData   = {4{mem_write_data[7:0]}};
        end
        OP_SH: begin
          w_storeStrobe = mem_sel << w_a;
          w_storeData   = {2{mem_write_data[15:0]}};
        end
        default: begin
          w_storeStrobe = mem_sel << w_a;
          w_storeData   = mem_write_data;
        end
      endcase
    end
  end

  load_formatter u_loadFormatter (
    .mem_op   (mem_op),
    .sign_ext (mem_sign_ext_flag),
    .a        (w_a),
    .mem_data (r_readData),
    .rt       (mem_write_data),
    .result   (w_loadResult)
  );

  // The request is captured on issue so the bus stays stable even if a flush
  // lets the pipeline change the MEM inputs while the access is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MEM_ST_IDLE;
      r_readData  <= 32'h0;
      r_reqAddr   <= 32'h0;
      r_reqData   <= 32'h0;
      r_reqStrobe <= 4'b0000;
      r_flushSeen <= 1'b0;
    end else begin
      case (r_state)
        MEM_ST_IDLE: begin
          if (w_access) begin
            r_reqAddr   <= w_wordAddr;
            r_reqData   <= w_storeData;
            r_reqStrobe <= w_storeStrobe;
            r_flushSeen <= 1'b0;
            if (ram_ready) begin
              r_readData <= ram_read_data;
              r_state    <= MEM_ST_DONE;
            end else begin
              r_state <= MEM_ST_WAIT;
            end
          end
        end
        MEM_ST_WAIT: begin
          if (flush) r_flushSeen <= 1'b1;
          if (ram_ready) begin
            r_readData  <= ram_read_data;
            r_flushSeen <= 1'b0;
            r_state     <= (r_flushSeen | flush) ? MEM_ST_IDLE : MEM_ST_DONE;
          end
        end
        MEM_ST_DONE: r_state <= MEM_ST_IDLE;
        default:     r_state <= MEM_ST_IDLE;
      endcase
    end
  end

  // IDLE answers in the same cycle; WAIT replays the captured request.
  always_comb begin
    ram_en           = 1'b0;
    ram_write_en     = 4'b0000;
    ram_addr         = 32'h0;
    ram_write_data   = 32'h0;
    result           = 32'h0;
    stall_request    = 1'b0;
    addr_error_load  = 1'b0;
    addr_error_store = 1'b0;
    if (!rst) begin
      case (r_state)
        MEM_ST_IDLE: begin
          if (w_access) begin
            ram_en         = 1'b1;
            stall_request  = 1'b1;
            ram_addr       = w_wordAddr;
            ram_write_en   = w_storeStrobe;
            ram_write_data = w_storeData;
          end else if (!flush) begin
            if (w_memInst) begin
              addr_error_load  = mem_read_flag;
              addr_error_store = mem_write_flag;
            end else begin
              result = result_in;
            end
          end
        end
        MEM_ST_WAIT: begin
          ram_en         = 1'b1;
          stall_request  = 1'b1;
          ram_addr       = r_reqAddr;
          ram_write_en   = r_reqStrobe;
          ram_write_data = r_reqData;
        end
        MEM_ST_DONE: result = mem_read_flag ? w_loadResult : result_in;
        default: result = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a byte-level
// arithmetic reference model of loads, stores and bus timing.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data, address, result_in;
  logic [5:0]  mem_op;
  logic        flush;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_ready;
  logic [31:0] result;
  logic        stall_request, addr_error_load, addr_error_store;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ALIGN_CHECK(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .mem_op            (mem_op),
    .address           (address),
    .result_in         (result_in),
    .flush             (flush),
    .ram_en            (ram_en),
    .ram_write_en      (ram_write_en),
    .ram_addr          (ram_addr),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .ram_ready         (ram_ready),
    .result            (result),
    .stall_request     (stall_request),
    .addr_error_load   (addr_error_load),
    .addr_error_store  (addr_error_store)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit isLoadOp(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic bit isStoreOp(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
  endfunction

  function automatic bit refMisaligned(input logic [5:0] op, input logic [31:0] addr);
    if (op inside {OP_LH, OP_LHU, OP_SH}) return (addr % 2) != 0;
    if (op inside {OP_LW, OP_SW})         return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] refStrobe(input logic [5:0] op, input int a);
    int s;
    case (op)
      OP_SB:   s = 1 << a;
      OP_SH:   s = 3 << a;
      OP_SW:   s = 15;
      OP_SWL:  s = (1 << (a + 1)) - 1;
      OP_SWR:  s = (15 << a) & 15;
      default: s = 0;
    endcase
    return s[3:0];
  endfunction

  function automatic logic [31:0] refStoreData(input logic [5:0] op, input int a, input logic [31:0] rt);
    case (op)
      OP_SB:   return (rt & 32'hFF) * 32'h01010101;
      OP_SH:   return (rt & 32'hFFFF) * 32'h00010001;
      OP_SWL:  return rt >> (24 - 8 * a);
      OP_SWR:  return rt << (8 * a);
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] refLoad(input logic [5:0] op, input bit sext, input int a,
                                          input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] v;
    int n;
    case (op)
      OP_LB, OP_LBU: begin
        v = (m >> (8 * a)) & 32'hFF;
        if (sext && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      OP_LH, OP_LHU: begin
        v = (m >> (16 * (a / 2))) & 32'hFFFF;
        if (sext && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      OP_LWL: begin
        n = 8 * (3 - a);
        v = (m << n) | (rt & ((32'h1 << n) - 32'h1));
      end
      OP_LWR: begin
        n = 8 * a;
        v = (m >> n) | (rt & ~(32'hFFFFFFFF >> n));
      end
      default: v = m;
    endcase
    return v;
  endfunction

  task automatic driveNop();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_op            = 6'h00;
    flush             = 1'b0;
    result_in         = $urandom;
    address           = $urandom;
    mem_write_data    = $urandom;
  endtask

  task automatic driveInst(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic fl);
    mem_op            = op;
    mem_read_flag     = isLoadOp(op);
    mem_write_flag    = isStoreOp(op);
    mem_sign_ext_flag = op inside {OP_LB, OP_LH, OP_LW};
    if (op inside {OP_LB, OP_LBU, OP_SB})      mem_sel = 4'b0001;
    else if (op inside {OP_LH, OP_LHU, OP_SH}) mem_sel = 4'b0011;
    else if (isLoadOp(op) || isStoreOp(op))    mem_sel = 4'b1111;
    else                                       mem_sel = 4'b0000;
    address        = addr;
    mem_write_data = rt;
    flush          = fl;
    result_in      = $urandom;
  endtask

  // One instruction from issue to retirement, followed by one idle cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                               input logic [31:0] mdata, input int waits, input logic fl,
                               output logic [31:0] obsResult, output logic [3:0] obsStrobe,
                               output logic [31:0] obsData);
    bit isMem, mis, acc, stalled;
    int n, a;
    logic [31:0] expResult;
    @(negedge clk);
    ram_ready = 1'b0;
    driveInst(op, addr, rt, fl);
    a     = int'(addr[1:0]);
    isMem = isLoadOp(op) || isStoreOp(op);
    mis   = isMem && refMisaligned(op, addr);
    acc   = isMem && !fl && !mis;
    obsStrobe = 4'b0000;
    obsData   = 32'h0;
    n = 0;
    stalled = 1'b1;
    while (stalled && n <= 20) begin
      #2;
      if (stall_request) begin
        checkOutput("ram_en_busy", 32'(ram_en), 32'd1);
        checkOutput("ram_addr", ram_addr, addr & 32'hFFFFFFFC);
        checkOutput("ram_write_en", 32'(ram_write_en), 32'(refStrobe(op, a)));
        if (isStoreOp(op)) checkOutput("ram_write_data", ram_write_data, refStoreData(op, a, rt));
        if (n == 0) begin
          obsStrobe = ram_write_en;
          obsData   = ram_write_data;
        end
        ram_read_data = (n == waits) ? mdata : $urandom;
        ram_ready     = (n == waits);
        n++;
        @(negedge clk);
        ram_ready = 1'b0;
      end else begin
        stalled = 1'b0;
      end
    end
    checkOutput("stall_cycles", 32'(n), acc ? 32'(waits + 1) : 32'd0);
    checkOutput("ram_en_after", 32'(ram_en), 32'd0);
    if (fl || mis)                  expResult = 32'h0;
    else if (!isMem || !isLoadOp(op)) expResult = result_in;
    else                            expResult = refLoad(op, op inside {OP_LB, OP_LH, OP_LW}, a, mdata, rt);
    checkOutput("result", result, expResult);
    checkOutput("addr_error_load", 32'(addr_error_load), 32'(mis && !fl && isLoadOp(op)));
    checkOutput("addr_error_store", 32'(addr_error_store), 32'(mis && !fl && isStoreOp(op)));
    obsResult = result;
    @(negedge clk);
    driveNop();
    ram_ready = 1'($urandom_range(0, 1));
    #2;
    checkOutput("idle_ram_en", 32'(ram_en), 32'd0);
    checkOutput("idle_result", result, result_in);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r, d;
    logic [3:0]  s;
    logic [5:0]  opList [13];
    logic [5:0]  op;
    logic [31:0] addr;
    opList = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
               OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, 6'h00};

    rst = 1'b1;
    ram_ready = 1'b0;
    ram_read_data = 32'h0;
    driveInst(OP_LW, 32'h0000_1000, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("rst_stall", 32'(stall_request), 32'd0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_ram_addr", ram_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    driveNop();
    #2;
    checkOutput("post_rst_result", result, result_in);
    checkOutput("post_rst_stall", 32'(stall_request), 32'd0);

    applyStimulus(OP_SB, 32'h0000_1002, 32'h0000_00A5, 32'h0, 0, 1'b0, r, s, d);
    checkOutput("plan_sb_strobe", 32'(s), 32'h4);
    checkOutput("plan_sb_data", d, 32'hA5A5_A5A5);
    applyStimulus(OP_LB, 32'h0000_2003, 32'h0, 32'h80FF_1234, 3, 1'b0, r, s, d);
    checkOutput("plan_lb", r, 32'hFFFF_FF80);
    applyStimulus(OP_LBU, 32'h0000_2003, 32'h0, 32'h80FF_1234, 3, 1'b0, r, s, d);
    checkOutput("plan_lbu", r, 32'h0000_0080);
    applyStimulus(OP_LWL, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 1, 1'b0, r, s, d);
    checkOutput("plan_lwl", r, 32'hCCDD_3344);
    applyStimulus(OP_LWR, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, r, s, d);
    checkOutput("plan_lwr", r, 32'h1122_AABB);
    applyStimulus(OP_SWR, 32'h0000_3001, 32'h1122_3344, 32'h0, 2, 1'b0, r, s, d);
    checkOutput("plan_swr_strobe", 32'(s), 32'hE);
    checkOutput("plan_swr_data", d, 32'h2233_4400);
    applyStimulus(OP_SWL, 32'h0000_3002, 32'h1122_3344, 32'h0, 0, 1'b0, r, s, d);
    checkOutput("plan_swl_strobe", 32'(s), 32'h7);
    checkOutput("plan_swl_data", d, 32'h0011_2233);
    applyStimulus(OP_LW, 32'h0000_4002, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, r, s, d);
    checkOutput("plan_lw_misaligned", r, 32'h0);
    applyStimulus(OP_LW, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, r, s, d);
    checkOutput("plan_flush_idle", r, 32'h0);

    // Flush during WAIT: bus finishes, then the controller is free again at once.
    @(negedge clk);
    ram_ready = 1'b0;
    driveInst(OP_LW, 32'h0000_5000, 32'h0, 1'b0);
    #2;
    checkOutput("fw_issue_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    driveInst(6'h00, $urandom, 32'h0, 1'b1);
    #2;
    checkOutput("fw_hold_en", 32'(ram_en), 32'd1);
    checkOutput("fw_hold_addr", ram_addr, 32'h0000_5000);
    @(negedge clk);
    driveInst(OP_LW, 32'h0000_6000, 32'h0, 1'b0);
    #2;
    checkOutput("fw_hold2_addr", ram_addr, 32'h0000_5000);
    checkOutput("fw_hold2_stall", 32'(stall_request), 32'd1);
    ram_read_data = 32'hCAFE_F00D;
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    #2;
    checkOutput("fw_next_en", 32'(ram_en), 32'd1);
    checkOutput("fw_next_addr", ram_addr, 32'h0000_6000);
    ram_read_data = 32'h1234_5678;
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    #2;
    checkOutput("fw_next_stall", 32'(stall_request), 32'd0);
    checkOutput("fw_next_result", result, 32'h1234_5678);

    // Reset while waiting abandons the transaction.
    @(negedge clk);
    driveInst(OP_LW, 32'h0000_7000, 32'h0, 1'b0);
    #2;
    checkOutput("rw_issue_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    #2;
    checkOutput("rw_wait_stall", 32'(stall_request), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_rst_en", 32'(ram_en), 32'd0);
    checkOutput("rw_rst_stall", 32'(stall_request), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    driveNop();
    #2;
    checkOutput("rw_after_en", 32'(ram_en), 32'd0);
    checkOutput("rw_after_stall", 32'(stall_request), 32'd0);
    checkOutput("rw_after_result", result, result_in);

    for (int i = 0; i < 200; i++) begin
      op   = opList[$urandom_range(0, 12)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      applyStimulus(op, addr, $urandom, $urandom, $urandom_range(0, 3),
                    1'($urandom_range(0, 9) == 0), r, s, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage consumer of the ID-stage memory control bundle: read/write/sign-ext flags, mem_sel, write data, and mem_op (carried through EX).
Turns each load/store into a single data-RAM bus transaction with a valid/ready handshake. Shifts store data and byte enables into lanes, and extracts, extends or merges load data (including LWL/LWR).
Stalls the pipeline until the bus completes. Non-memory instructions pass through untouched.

Parameters:
ALIGN_CHECK, 1, 1 = detect misaligned LH/LHU/SH/LW/SW and suppress the bus access; 0 = no check, address passed as-is.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
mem_read_flag  in  1  load instruction in MEM
mem_write_flag  in  1  store instruction in MEM
mem_sign_ext_flag  in  1  sign-extend load result (LB/LH/LW)
mem_sel  in  4  access size: 0001 byte, 0011 half, 1111 word/unaligned
mem_write_data  in  32  rt value: store data, or merge source for LWL/LWR
mem_op  in  6  opcode (`INST_OP_BUS), distinguishes LWL/LWR/SWL/SWR/LBU/LHU
address  in  32  effective byte address from EX
result_in  in  32  EX result for non-memory instructions
flush  in  1  kill the instruction in MEM
ram_en  out  1  bus request valid
ram_write_en  out  4  per-byte write strobe; 0000 = read
ram_addr  out  32  word-aligned address ({address[31:2],2'b00})
ram_write_data  out  32  lane-aligned store data
ram_read_data  in  32  read data, valid with ram_ready
ram_ready  in  1  bus completion; sampled only while ram_en=1
result  out  32  value forwarded to WB
stall_request  out  1  hold IF..MEM stages
addr_error_load  out  1  misaligned load (one cycle)
addr_error_store  out  1  misaligned store (one cycle)

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset: state=IDLE, latched read data=0. All outputs are 0 during and after reset. A reset in WAIT abandons the bus transaction.
- access = (read|write) & ~flush & ~misaligned.
- IDLE
  - access=1: ram_en=1, stall_request=1.
  - ram_ready=1 in the same cycle: latch ram_read_data and go to DONE.
  - Otherwise go to WAIT.
  - No access: ram_en=0, stall_request=0, result=result_in.
- WAIT
  - ram_en=1, stall_request=1. Address, strobe and data are held stable from the stalled inputs.
  - On ram_ready: latch data. Go to DONE, or to IDLE if flush was seen during WAIT (sticky flag; the bus cannot be cancelled).
- DONE
  - ram_en=0, stall_request=0.
  - result = formatted latched data for loads, result_in for stores.
  - Always go to IDLE next cycle.
- Minimum latency: one stall cycle (zero-wait bus). An N-wait bus gives N+1 stall cycles.
- Misaligned (ALIGN_CHECK=1): LH/LHU/SH with address[0]=1; LW/SW with address[1:0]≠0.
  - Response: no ram_en, no stall, addr_error_load or addr_error_store=1 for that cycle, result=0.
  - LWL/LWR/SWL/SWR/LB/LBU/SB are never misaligned.
- Store lanes (little-endian, a=address[1:0]):
  - SB: strobe 0001<<a, data {4{rt[7:0]}}.
  - SH: strobe 0011<<a, data {2{rt[15:0]}}.
  - SW: strobe 1111, data rt.
  - SWL, a=0..3: strobe 0001/0011/0111/1111; data rt>>(24-8a).
  - SWR, a=0..3: strobe 1111/1110/1100/1000; data rt<<8a.
- Load format:
  - LB/LBU: byte at lane a; sign- or zero-extended per mem_sign_ext_flag.
  - LH/LHU: half at address[1]; sign- or zero-extended per mem_sign_ext_flag.
  - LW: full word.
  - LWL, a=0..3: {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
  - LWR, a=0..3: m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
- Flush in IDLE: no request issued, result=0.
- ram_ready while ram_en=0 is ignored.

Decomposition:
- bus.v: ADDR_BUS (31:0), MEM_SEL_BUS (3:0), MEM_STATE_BUS (1:0) with MEM_ST_IDLE/WAIT/DONE encodings.
- opcode.v: OP_* load/store opcodes, already shared.
- One combinational sub-module, load_formatter (inputs mem_op, sign_ext, a, latched data, rt; output 32-bit result), keeps lane/merge logic out of the FSM.

Test Plan:
- SB, address=0x1002, rt=0x000000A5, zero-wait bus -> one stall cycle; ram_addr=0x1000, ram_write_en=0100, ram_write_data=0xA5A5A5A5; next cycle stall=0.
- LB, address=0x2003, memory word 0x80FF1234, ram_ready after 3 cycles -> stall held 4 cycles; result=0xFFFFFF80. LBU, same setup -> 0x00000080.
- LWL, a=1, m=0xAABBCCDD, rt=0x11223344 -> result=0xCCDD3344. LWR, a=2, same m and rt -> 0x1122AABB.
- SWR, address=0x3001, rt=0x11223344 -> strobe 1110, data 0x22334400. SWL, a=2 -> strobe 0111, data 0x00112233.
- LW, address=0x4002 -> ram_en stays 0, addr_error_load=1 for one cycle, stall=0, result=0.
- Flush asserted in WAIT -> ram_en held until ram_ready, then IDLE without DONE. Separately, rst in WAIT -> ram_en=0, stall=0 next cycle.
